ifu_fetch_ctrl: RTL and testbench
=================================

Name: ifu_fetch_ctrl

Overview:
Instruction-fetch sequencer for the NPC core.
- Owns the PC and drives the instruction ROM / imem port with a valid/ready request and a valid-only response.
- Presents fetched instructions to decode through a valid/ready handshake.
- Accepts branch/jump redirects from EXU and a halt (ebreak) request.
- Keeps at most one imem request outstanding.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset; first fetch address.
- XLEN, 32, address and instruction width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous assert, active-low
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  imem accepts request
- imem_addr  out  XLEN  fetch address (= pc)
- imem_rsp_valid  in  1  response data valid (one pulse per accepted request)
- imem_rsp_data  in  XLEN  fetched instruction word
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts instruction
- inst_pc  out  XLEN  PC of presented instruction
- inst_data  out  XLEN  presented instruction
- redirect_valid  in  1  one-cycle redirect pulse from EXU
- redirect_pc  in  XLEN  redirect target
- halt  in  1  stop fetching (level)
- halted  out  1  controller in S_HALT
- misalign_err  out  1  sticky: redirect target had pc[1:0] != 0

Behaviour:
- Reset (rst_n=0, async): pc=RESET_PC, state=S_REQ, drop=0, inst_valid=0, inst_pc=0, inst_data=0, halted=0, misalign_err=0.
  - imem_req_valid is forced 0 while rst_n=0.
- FSM states S_REQ, S_WAIT, S_HOLD, S_HALT.
- Decoded outputs: imem_req_valid = (state==S_REQ) && !redirect_valid && !halt; imem_addr = pc.
- S_REQ:
  - redirect_valid: pc<=redirect_pc, no request issued, stay S_REQ.
  - else halt: ->S_HALT.
  - else req_valid&&req_ready: ->S_WAIT.
- S_WAIT:
  - rsp_valid && (drop || redirect_valid): discard data, drop<=0, ->S_REQ.
  - rsp_valid otherwise: inst_data<=rsp_data, inst_pc<=pc, inst_valid<=1, pc<=pc+4, ->S_HOLD.
  - redirect_valid without rsp_valid: pc<=redirect_pc, drop<=1, stay S_WAIT.
  - Halt has no effect in S_WAIT; the outstanding response always completes.
- S_HOLD:
  - inst_valid=1; inst_pc and inst_data stay stable until the handshake completes.
  - inst_ready: inst_valid<=0, ->S_REQ.
  - redirect_valid: inst_valid<=0, pc<=redirect_pc, ->S_REQ, regardless of inst_ready (a same-cycle handshake counts as consumed).
- S_HALT: no requests; inst_valid=0; halted=1. Sticky until reset. Redirects are ignored.
- Misalignment: redirect_valid with redirect_pc[1:0]!=0 in any non-HALT state sets misalign_err<=1 and ->S_HALT. pc is not updated and inst_valid<=0.
  - If this happens in S_WAIT, the pending response is still absorbed: enter S_HALT with drop=1 and ignore rsp_valid there.
- Arithmetic: pc+4 is modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0.
- Latency with zero-wait imem (req_ready=1, rsp one cycle after accept): request at cycle n, inst_valid at n+2. Steady-state throughput is 1 instruction per 3 cycles when inst_ready=1.
- Protocol: rsp_valid outside S_WAIT/S_HALT is a protocol violation; the block carries an assertion for it.

Decomposition:
- Shared package npc_pkg:
  - fetch state enum (S_REQ, S_WAIT, S_HOLD, S_HALT)
  - RESET_PC constant 32'h8000_0000
  - XLEN
  - INST_NOP = 32'h0000_0013
- No sub-module; the PC, state, drop flag and output register fit in one module.

Test Plan:
- Reset then zero-wait imem, inst_ready=1 → imem_addr 80000000, 80000004, 80000008; inst_pc matches; inst_valid every 3rd cycle.
- inst_ready=0 for 5 cycles in S_HOLD → inst_valid, inst_pc=80000000 and inst_data stable; no new request until ready.
- Redirect to 80000100 in S_WAIT, response arrives 2 cycles later → response dropped; next imem_addr=80000100; no inst_valid for the stale word.
- Redirect to 80000040 in the same cycle as rsp_valid → data discarded; next request at 80000040. Also redirect in S_HOLD with inst_ready=1 → next request at target.
- halt=1 while in S_WAIT → pending instruction delivered, then halted=1 and imem_req_valid stays 0 for 20 cycles.
- redirect_pc=80000102 → misalign_err=1, halted=1, no further requests. rst_n pulsed low mid-S_WAIT → all outputs return to reset values asynchronously; fetch restarts at 80000000.

Source files
------------

// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared NPC core types and constants
//
// Shared by the fetch controller, its bundle interface and the testbench.
//   XLEN          address / instruction width
//   RESET_PC      first fetch address after reset
//   INST_NOP      canonical addi x0,x0,0 encoding
//   fetch_state_e fetch sequencer states
package npc_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } fetch_state_e;

  // RV32 without the C extension: instruction addresses must be word aligned.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// rtl/ifu_fetch_ctrl_if.sv - imem and decode handshakes of the fetch controller
//
// Groups the instruction-memory port (valid/ready request, valid-only
// response) and the decode-side valid/ready instruction handshake.
//   master : fetch controller side (drives requests, presents instructions)
//   slave  : environment side (imem + decode)
interface ifu_fetch_ctrl_if #(
  parameter int XLEN = npc_pkg::XLEN
) ();

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst_data;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst_pc, inst_data,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst_pc, inst_data,
    output inst_ready
  );

endinterface

// File: rtl/ifu_fetch_ctrl.sv
// rtl/ifu_fetch_ctrl.sv - instruction-fetch sequencer for the NPC core
//
// Owns the PC, issues one imem request at a time, presents each fetched
// word to decode and reacts to EXU redirects and the ebreak halt.
// Ports:
//   clk, rst_n       core clock, asynchronous active-low reset
//   bus (master)     imem request/response and decode instruction handshake
//   redirect_valid   one-cycle redirect pulse from EXU
//   redirect_pc      redirect target
//   halt             level request to stop fetching
//   halted           controller is parked in S_HALT
//   misalign_err     sticky: a redirect target was not word aligned
module ifu_fetch_ctrl #(
  parameter int              XLEN     = npc_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = npc_pkg::RESET_PC
) (
  input  logic                clk,
  input  logic                rst_n,
  ifu_fetch_ctrl_if.master    bus,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  input  logic                halt,
  output logic                halted,
  output logic                misalign_err
);

  import npc_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [XLEN-1:0] inst_data_q, inst_data_d;
  logic            drop_q, drop_d;
  logic            err_q, err_d;

  logic            redirect_bad;
  logic            req_fire;

  assign redirect_bad = redirect_valid && is_misaligned(redirect_pc);

  // A redirect or halt in the request cycle suppresses the request so the
  // stale PC is never sent; rst_n gates it so nothing leaks out during reset.
  assign bus.imem_req_valid = rst_n && (state_q == S_REQ) && !redirect_valid && !halt;
  assign bus.imem_addr      = pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign bus.inst_valid = (state_q == S_HOLD);
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_data  = inst_data_q;
  assign halted         = (state_q == S_HALT);
  assign misalign_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      inst_pc_q   <= '0;
      inst_data_q <= '0;
      drop_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_pc_q   <= inst_pc_d;
      inst_data_q <= inst_data_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_pc_d   = inst_pc_q;
    inst_data_d = inst_data_q;
    drop_d      = drop_q;
    err_d       = err_q;

    unique case (state_q)
      S_REQ: begin
        if (redirect_bad) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (halt) begin
          state_d = S_HALT;
        end else if (req_fire) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_bad) begin
          // The outstanding response still arrives; S_HALT swallows it.
          err_d   = 1'b1;
          drop_d  = 1'b1;
          state_d = S_HALT;
        end else if (bus.imem_rsp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
            if (redirect_valid) begin
              pc_d = redirect_pc;
            end
          end else begin
            inst_data_d = bus.imem_rsp_data;
            inst_pc_d   = pc_q;
            pc_d        = pc_q + XLEN'(4);
            state_d     = S_HOLD;
          end
        end else if (redirect_valid) begin
          // Response for the old PC is still in flight; mark it stale.
          pc_d   = redirect_pc;
          drop_d = 1'b1;
        end
      end

      S_HOLD: begin
        // Redirect wins over a same-cycle handshake: the word was consumed
        // by decode but the flow continues at the redirect target.
        if (redirect_bad) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (bus.inst_ready) begin
          state_d = S_REQ;
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // A response may only arrive while one is outstanding (S_WAIT), or after a
  // misaligned redirect parked the sequencer in S_HALT with one in flight.
  a_rsp_window: assert property (@(posedge clk) disable iff (!rst_n)
    bus.imem_rsp_valid |-> (state_q == S_WAIT || state_q == S_HALT));

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb/tb_ifu_fetch_ctrl.sv - randomized bench for ifu_fetch_ctrl against a flag-level model
module tb_ifu_fetch_ctrl;

  import npc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;
  logic        misalign_err;

  always #5 clk = ~clk;

  ifu_fetch_ctrl_if #(.XLEN(32)) bus ();

  ifu_fetch_ctrl #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .halted         (halted),
    .misalign_err   (misalign_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain flags describing what the fetch unit is doing.
  bit          m_busy;    // an imem request has been accepted, response pending
  bit          m_stale;   // pending response belongs to an abandoned PC
  bit          m_have;    // an instruction is on offer to decode
  bit          m_halted;
  bit          m_err;
  logic [31:0] m_pc, m_ipc, m_idata;

  // imem responder state
  int          rsp_wait;
  logic [31:0] rsp_addr;

  // stimulus knobs (percentages, max response delay)
  int unsigned pct_rdy, pct_irdy, pct_redir, pct_mis, pct_halt, max_dly;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_stale = 0; m_have = 0; m_halted = 0; m_err = 0;
    m_pc = 32'h8000_0000; m_ipc = '0; m_idata = '0;
    rsp_wait = 0; rsp_addr = '0;
  endtask

  function automatic bit exp_req();
    return rst_n && !m_busy && !m_have && !m_halted && !redirect_valid && !halt;
  endfunction

  task automatic check_outputs();
    check("imem_req_valid", 32'(bus.imem_req_valid), 32'(exp_req()));
    check("imem_addr",      bus.imem_addr,           m_pc);
    check("inst_valid",     32'(bus.inst_valid),     32'(m_have));
    check("inst_pc",        bus.inst_pc,             m_ipc);
    check("inst_data",      bus.inst_data,           m_idata);
    check("halted",         32'(halted),             32'(m_halted));
    check("misalign_err",   32'(misalign_err),       32'(m_err));
  endtask

  // Advance the model across one rising edge with the currently driven inputs.
  task automatic model_step();
    bit r, v;
    r = redirect_valid;
    v = bus.imem_rsp_valid;
    if (m_halted) begin
      if (v) m_busy = 0;
    end else if (r && redirect_pc[1:0] != 2'b00) begin
      m_err = 1; m_halted = 1; m_have = 0;
      if (v) m_busy = 0;
    end else if (m_busy) begin
      if (v) begin
        m_busy = 0;
        if (m_stale || r) begin
          m_stale = 0;
          if (r) m_pc = redirect_pc;
        end else begin
          m_have = 1; m_ipc = m_pc; m_idata = bus.imem_rsp_data; m_pc = m_pc + 32'd4;
        end
      end else if (r) begin
        m_pc = redirect_pc; m_stale = 1;
      end
    end else if (m_have) begin
      if (r) begin m_have = 0; m_pc = redirect_pc; end
      else if (bus.inst_ready) m_have = 0;
    end else begin
      if (r) m_pc = redirect_pc;
      else if (halt) m_halted = 1;
      else if (bus.imem_req_ready) m_busy = 1;
    end
  endtask

  function automatic logic [31:0] pick_target(input bit misaligned);
    logic [31:0] t;
    case ($urandom_range(3))
      0: t = 32'h8000_0100;
      1: t = 32'h8000_0040;
      2: t = 32'hFFFF_FFFC;
      default: t = $urandom() & 32'hFFFF_FFFC;
    endcase
    if (misaligned) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  task automatic run_cycle();
    bit          accept;
    logic [31:0] acc_addr;
    @(negedge clk);
    redirect_valid     = ($urandom_range(99) < pct_redir);
    redirect_pc        = pick_target($urandom_range(99) < pct_mis);
    halt               = ($urandom_range(99) < pct_halt);
    bus.imem_req_ready = ($urandom_range(99) < pct_rdy);
    bus.inst_ready     = ($urandom_range(99) < pct_irdy);
    if (rsp_wait == 1) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(rsp_addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom();
    end
    #1;
    check_outputs();
    accept   = exp_req() && bus.imem_req_ready;
    acc_addr = m_pc;
    model_step();
    if (rsp_wait > 0) rsp_wait--;
    if (accept) begin
      rsp_wait = int'($urandom_range(1, max_dly));
      rsp_addr = acc_addr;
    end
  endtask

  task automatic quiet_inputs();
    redirect_valid = 0; redirect_pc = '0; halt = 0;
    bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0;
    bus.inst_ready = 0;
  endtask

  // Assert reset away from any clock edge and check outputs fall immediately.
  task automatic do_reset();
    #2;
    quiet_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic knobs(input int unsigned rdy, irdy, redir, mis, hlt, dly);
    pct_rdy = rdy; pct_irdy = irdy; pct_redir = redir; pct_mis = mis; pct_halt = hlt; max_dly = dly;
  endtask

  initial begin
    quiet_inputs();
    model_reset();
    rst_n = 1'b0;
    knobs(100, 100, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // zero-wait imem, decode always ready: sequential fetch
    for (int i = 0; i < 30; i++) run_cycle();

    // decode stalls: held instruction must stay stable
    knobs(100, 15, 0, 0, 0, 1);
    for (int i = 0; i < 60; i++) run_cycle();

    // redirects with slow imem, including the wrap-around target
    knobs(70, 60, 20, 0, 0, 3);
    for (int i = 0; i < 600; i++) run_cycle();

    // halt raised once a request is outstanding
    knobs(100, 100, 0, 0, 0, 3);
    for (int i = 0; i < 50 && !m_busy; i++) run_cycle();
    knobs(100, 100, 0, 0, 100, 3);
    for (int i = 0; i < 30; i++) run_cycle();

    // misaligned redirects; restart after each halt, async reset mid-wait
    do_reset();
    for (int round = 0; round < 12; round++) begin
      knobs(80, 70, 15, 20, 2, 3);
      for (int i = 0; i < 120; i++) run_cycle();
      knobs(100, 100, 0, 0, 0, 3);
      for (int i = 0; i < 40 && !m_busy && !m_halted; i++) run_cycle();
      do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, got %0d checks expected completion", n_checks);
    $fatal(1);
  end

endmodule
